serial_load_ctrl: RTL and testbench

Upstream stage for the enable-D flip-flop register bank. Collects a serial bit stream into a WIDTH-bit word and, when the word is complete, drives it onto the bank's parallel D inputs with a one-cycle enable strobe E. Between strobes, D is held stable so the downstream flops see clean setup/hold windows around every CK edge.

---
 rtl/serial_load_ctrl.sv | 90 +++++++++
 tb/tb_serial_load_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/serial_load_ctrl.sv
// serial_load_ctrl: collects SIN/SVALID bits into a WIDTH-bit word and loads it onto D with a one-cycle E strobe; define PARITY_CHK_EN to add an even-parity bit check (ports: CK, R async reset, START, SIN, SVALID, ABORT in; D, E, BUSY, PERR out)
module serial_load_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CK,
  input  logic             R,
  input  logic             START,
  input  logic             SIN,
  input  logic             SVALID,
  input  logic             ABORT,
  output logic [WIDTH-1:0] D,
  output logic             E,
  output logic             BUSY,
  output logic             PERR
);
  localparam int CW = $clog2(WIDTH) + 1;
`ifdef PARITY_CHK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr, nxt, word;
  logic shift, load, last;
  assign nxt  = MSB_FIRST ? {sr[WIDTH-2:0], SIN} : {SIN, sr[WIDTH-1:1]};
  assign last = cnt == CW'(WIDTH - 1);
`ifdef PARITY_CHK_EN
  logic perr_n;
  assign word = sr;
`else
  assign word = nxt;
  assign PERR = 1'b0;
`endif
  always_ff @(posedge CK or posedge R)
    if (R) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    shift   = 1'b0;
    load    = 1'b0;
`ifdef PARITY_CHK_EN
    perr_n  = 1'b0;
`endif
    case (state)
      IDLE: state_n = START && !ABORT ? SHIFT : IDLE;
      SHIFT:
        if (ABORT) state_n = IDLE;
        else if (SVALID) begin
          shift = 1'b1;
`ifdef PARITY_CHK_EN
          state_n = last ? PAR : SHIFT;
`else
          load    = last;
          state_n = last ? IDLE : SHIFT;
`endif
        end
`ifdef PARITY_CHK_EN
      PAR:
        if (ABORT) state_n = IDLE;
        else if (SVALID) begin
          state_n = IDLE;
          perr_n  = ^{sr, SIN};
          load    = ~^{sr, SIN};
        end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CK or posedge R)
    if (R) begin
      cnt  <= '0;
      sr   <= '0;
      D    <= '0;
      E    <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      cnt  <= (state != SHIFT || ABORT) ? '0 : (shift && !last) ? cnt + CW'(1) : cnt;
      if (shift) sr <= nxt;
      if (load) D <= word;
      E    <= load;
      BUSY <= state_n != IDLE;
    end
`ifdef PARITY_CHK_EN
  always_ff @(posedge CK or posedge R)
    if (R) PERR <= 1'b0;
    else PERR <= perr_n;
`endif
endmodule

// File: tb/tb_serial_load_ctrl.sv
// tb_serial_load_ctrl: randomized scoreboard bench driving an MSB-first and an LSB-first instance in parallel
module tb_serial_load_ctrl;
`ifdef PARITY_CHK_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int NB = PAR_ON ? 9 : 8;
  typedef struct {
    logic [7:0] w0;
    logic [7:0] w1;
    bit         err;
    int         cyc;
  } item_t;
  logic CK = 1'b0, R = 1'b1, START = 1'b0, SIN = 1'b0, SVALID = 1'b0, ABORT = 1'b0;
  logic [7:0] d [2];
  logic e [2], busy [2], perr [2];
  item_t q[$];
  logic [7:0] exp_d0 = '0, exp_d1 = '0;
  int checks = 0, errors = 0, cyc = 0;
  bit done = 1'b0;
  serial_load_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .CK(CK), .R(R), .START(START), .SIN(SIN), .SVALID(SVALID), .ABORT(ABORT),
    .D(d[0]), .E(e[0]), .BUSY(busy[0]), .PERR(perr[0]));
  serial_load_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .CK(CK), .R(R), .START(START), .SIN(SIN), .SVALID(SVALID), .ABORT(ABORT),
    .D(d[1]), .E(e[1]), .BUSY(busy[1]), .PERR(perr[1]));
  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge CK);
    #1;
  endtask
  function automatic logic [7:0] rev(input logic [7:0] w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = w[7-k];
    return r;
  endfunction
  // bits go out in the order w[7], w[6], ... w[0], then the parity bit when enabled
  task automatic send_word(input logic [7:0] w, input int gap_pct, input int gap_at, input int gap_n,
                           input bit abort_last, input bit corrupt);
    item_t it;
    bit c;
    c = PAR_ON && corrupt;
    START = 1'b1;
    tick();
    chk("busy_start", busy[0], 1);
    for (int i = 0; i < NB; i++) begin
      if (i == gap_at)
        repeat (gap_n) begin
          SVALID = 1'b0;
          START  = 1'($urandom);
          tick();
          chk("busy_gap", busy[1], 1);
        end
      while (int'($urandom_range(99)) < gap_pct) begin
        SVALID = 1'b0;
        SIN    = 1'($urandom);
        tick();
        chk("busy_rgap", busy[0], 1);
      end
      SIN    = i < 8 ? w[7-i] : (^w) ^ c;
      SVALID = 1'b1;
      START  = 1'($urandom);
      ABORT  = abort_last && i == NB - 1;
      tick();
    end
    SVALID = 1'b0;
    START  = 1'b0;
    if (abort_last) chk("busy_abort", busy[0], 0);
    else begin
      it.w0 = w;
      it.w1 = rev(w);
      it.err = c;
      it.cyc = cyc;
      q.push_back(it);
    end
    ABORT = 1'b0;
  endtask
  always @(negedge CK)
    if (!R && !done) begin
      if (e[0] || e[1] || perr[0] || perr[1]) begin
        if (q.size() == 0) chk("spurious_strobe", {e[0], e[1], perr[0], perr[1]}, 0);
        else begin
          item_t it;
          it = q.pop_front();
          chk("e_msb", e[0], !it.err);
          chk("e_lsb", e[1], !it.err);
          chk("perr_msb", perr[0], it.err);
          chk("perr_lsb", perr[1], it.err);
          chk("latency", cyc, it.cyc);
          if (!it.err) begin
            exp_d0 = it.w0;
            exp_d1 = it.w1;
          end
        end
      end
      chk("d_msb", d[0], exp_d0);
      chk("d_lsb", d[1], exp_d1);
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    #1;
    chk("rst_d", d[0], 0);
    chk("rst_e", e[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_perr", perr[0], 0);
    tick();
    tick();
    R = 1'b0;
    tick();
    send_word(8'hA5, 0, -1, 0, 0, 0);
    repeat (20) tick();
    send_word(8'hC0, 0, -1, 0, 0, 0);
    tick();
    send_word(8'hA5, 0, 4, 3, 0, 0);
    tick();
    send_word(8'h5A, 0, -1, 0, 1, 0);
    tick();
    send_word(8'hA5, 0, -1, 0, 0, 0);
    send_word(8'h3C, 0, -1, 0, 0, 0);
    tick();
    START = 1'b1;
    ABORT = 1'b1;
    tick();
    START = 1'b0;
    ABORT = 1'b0;
    chk("start_abort_idle", busy[0], 0);
    repeat (5) begin
      SIN = 1'($urandom);
      SVALID = 1'b1;
      tick();
      chk("idle_ignore", busy[0], 0);
    end
    SVALID = 1'b0;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (3) begin
      SIN = 1'b1;
      SVALID = 1'b1;
      tick();
    end
    SVALID = 1'b0;
    #2 R = 1'b1;
    #1;
    chk("async_d", d[0], 0);
    chk("async_d_lsb", d[1], 0);
    chk("async_e", e[0], 0);
    chk("async_busy", busy[0], 0);
    exp_d0 = '0;
    exp_d1 = '0;
    tick();
    R = 1'b0;
    tick();
    send_word(8'hA5, 0, -1, 0, 0, 0);
    tick();
    send_word(8'hA5, 0, -1, 0, 0, 1);
    tick();
    for (int n = 0; n < 60; n++) begin
      send_word(8'($urandom), 30, -1, 0, $urandom_range(9) == 0, $urandom_range(4) == 0);
      repeat ($urandom_range(3)) tick();
    end
    repeat (4) tick();
    chk("queue_drained", q.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
